q100_wb_arb: RTL

Q100_WB_ARB -- requirements
Module: q100_wb_arb

---
 rtl/q100_wb_arb_if.sv | 34 +++
 rtl/q100_config.svh | 9 +
 rtl/q100_wb_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/q100_wb_arb_if.sv
// Writeback bus between the two result producers, the arbiter and the register file.
`include "q100_config.svh"

interface q100_wb_arb_if;
    logic                    pipe_vld_i;
    logic [`LEN_RD-1:0]      pipe_rd_i;
    logic [`LEN_REG_VAL-1:0] pipe_data_i;
    logic                    pipe_rdy_o;

    logic                    ll_vld_i;
    logic [`LEN_RD-1:0]      ll_rd_i;
    logic [`LEN_REG_VAL-1:0] ll_data_i;
    logic                    ll_rdy_o;

    logic [`LEN_REG_VAL-1:0] xn_result_o;
    logic [`LEN_REG-1:0]     xn_wr_en_o;
    logic                    reg_wr;
    logic [`LEN_RD-1:0]      rd_o;
    logic                    grant_ll_o;

    modport slave (
        input  pipe_vld_i, pipe_rd_i, pipe_data_i,
        input  ll_vld_i, ll_rd_i, ll_data_i,
        output pipe_rdy_o, ll_rdy_o,
        output xn_result_o, xn_wr_en_o, reg_wr, rd_o, grant_ll_o
    );

    modport master (
        output pipe_vld_i, pipe_rd_i, pipe_data_i,
        output ll_vld_i, ll_rd_i, ll_data_i,
        input  pipe_rdy_o, ll_rdy_o,
        input  xn_result_o, xn_wr_en_o, reg_wr, rd_o, grant_ll_o
    );
endinterface

// File: rtl/q100_config.svh
// Shared register-file geometry for the q100 core.
`ifndef Q100_CONFIG_SVH
`define Q100_CONFIG_SVH

`define LEN_REG_VAL 32
`define LEN_RD      5
`define LEN_REG     32

`endif

// File: rtl/q100_wb_arb.sv
// Writeback arbiter: pipeline vs long-latency unit into one register-file write port.
// Macro Q100_WB_ARB_STARVE_EN enables the anti-starvation priority FSM; otherwise pipe always wins.
//
// state    | meaning
// PIPE_PRI | pipe wins a conflict; starve counter tracks ll losses
// LL_PRI   | ll wins a conflict; left on the next ll acceptance
`include "q100_config.svh"

module q100_wb_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    q100_wb_arb_if.slave  bus
);

    localparam int LP_VAL = `LEN_REG_VAL;
    localparam int LP_RD  = `LEN_RD;
    localparam int LP_REG = `LEN_REG;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("q100_wb_arb: STARVE_MAX must be in 1..15");
    end

    logic              w_pipe_rdy;
    logic              w_ll_rdy;
    logic              w_pipe_acc;
    logic              w_ll_acc;
    logic              w_any_acc;
    logic [LP_RD-1:0]  w_sel_rd;
    logic [LP_VAL-1:0] w_sel_data;
    logic [LP_REG-1:0] w_sel_wr_en;

    logic [LP_VAL-1:0] r_result;
    logic [LP_REG-1:0] r_wr_en;
    logic              r_reg_wr;
    logic [LP_RD-1:0]  r_rd;
    logic              r_grant_ll;

    assign w_pipe_acc = bus.pipe_vld_i & w_pipe_rdy;
    assign w_ll_acc   = bus.ll_vld_i & w_ll_rdy;
    assign w_any_acc  = w_pipe_acc | w_ll_acc;

`ifdef Q100_WB_ARB_STARVE_EN
    typedef enum logic {
        PIPE_PRI = 1'b0,
        LL_PRI   = 1'b1
    } state_t;

    localparam logic [3:0] LP_STARVE_LAST = 4'(STARVE_MAX - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PIPE_PRI;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_ll_acc) begin
            w_starve_cnt_nxt = 4'd0;
            w_state_nxt      = PIPE_PRI;
        end else if (r_state == PIPE_PRI && bus.ll_vld_i && w_pipe_acc) begin
            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
            if (r_starve_cnt == LP_STARVE_LAST) begin
                w_state_nxt = LL_PRI;
            end
        end
    end

    always_comb begin
        w_pipe_rdy = 1'b0;
        w_ll_rdy   = 1'b0;
        if (!rst) begin
            case (r_state)
                PIPE_PRI: begin
                    w_pipe_rdy = 1'b1;
                    w_ll_rdy   = ~bus.pipe_vld_i;
                end
                LL_PRI: begin
                    w_ll_rdy   = 1'b1;
                    w_pipe_rdy = ~bus.ll_vld_i;
                end
                default: begin
                    w_pipe_rdy = 1'b0;
                    w_ll_rdy   = 1'b0;
                end
            endcase
        end
    end
`else
    always_comb begin
        w_pipe_rdy = ~rst;
        w_ll_rdy   = ~rst & ~bus.pipe_vld_i;
    end
`endif

    // Readies are mutually exclusive under conflict, so ll_acc alone identifies the source.
    always_comb begin
        w_sel_rd    = w_ll_acc ? bus.ll_rd_i   : bus.pipe_rd_i;
        w_sel_data  = w_ll_acc ? bus.ll_data_i : bus.pipe_data_i;
        w_sel_wr_en = '0;
        if (w_sel_rd != '0) begin
            w_sel_wr_en = {{(LP_REG-1){1'b0}}, 1'b1} << w_sel_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_wr_en    <= '0;
            r_reg_wr   <= 1'b0;
            r_rd       <= '0;
            r_grant_ll <= 1'b0;
        end else begin
            r_reg_wr   <= w_any_acc && (w_sel_rd != '0);
            r_wr_en    <= w_any_acc ? w_sel_wr_en : '0;
            r_grant_ll <= w_ll_acc;
            if (w_any_acc) begin
                r_rd     <= w_sel_rd;
                r_result <= w_sel_data;
            end
        end
    end

    assign bus.pipe_rdy_o  = w_pipe_rdy;
    assign bus.ll_rdy_o    = w_ll_rdy;
    assign bus.xn_result_o = r_result;
    assign bus.xn_wr_en_o  = r_wr_en;
    assign bus.reg_wr      = r_reg_wr;
    assign bus.rd_o        = r_rd;
    assign bus.grant_ll_o  = r_grant_ll;

endmodule
